// File: rtl/forwarding_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_hazard_unit_pkg
//  Description : Shared constants for the forwarding / hazard control slice.
//                - Forward-select encodings driven to the EX operand muxes:
//                  FWD_REG (register file), FWD_MEM (resultadoALU_MEM) and
//                  FWD_WB (resultadoMux_WB).
//                - Default register-address width.
//                - Instruction word used as a NOP on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
package forwarding_hazard_unit_pkg;

   localparam int REG_W = 3;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // All-zero word decodes as a no-op with every control bit cleared.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Combinational forward-select for one ALU operand.
//                Compares the operand's source register against the EX/MEM
//                and MEM/WB destination shadows; the EX/MEM match wins because
//                it carries the newer value.
//  Ports       : srcReg           - source register of the operand in EX
//                exMemRd/exMemWe  - EX/MEM destination and write enable
//                memWbRd/memWbWe  - MEM/WB destination and write enable
//                fwdSel           - FWD_REG / FWD_MEM / FWD_WB select code
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select #(
   parameter int REG_W    = 3,
   parameter int ZERO_REG = 1
) (
   input  logic [REG_W-1:0] srcReg,
   input  logic [REG_W-1:0] exMemRd,
   input  logic             exMemWe,
   input  logic [REG_W-1:0] memWbRd,
   input  logic             memWbWe,
   output logic [1:0]       fwdSel
);
   import forwarding_hazard_unit_pkg::*;

   logic w_srcLive;
   logic w_exMemHit;
   logic w_memWbHit;

   // A hardwired-zero source never needs a forwarded value.
   assign w_srcLive  = (ZERO_REG == 0) || (srcReg != '0);
   assign w_exMemHit = w_srcLive && exMemWe && (exMemRd == srcReg);
   assign w_memWbHit = w_srcLive && memWbWe && (memWbRd == srcReg);

   always_comb begin
      fwdSel = FWD_REG;
      if (w_exMemHit) begin
         fwdSel = FWD_MEM;
      end else if (w_memWbHit) begin
         fwdSel = FWD_WB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_hazard_unit
//  Description : Control-side partner of the EX stage datapath. Produces the
//                operand forward selects, detects load-use hazards (stall
//                IF/ID plus an ID/EX bubble), flushes IF/ID on a taken branch
//                and counts load-use stall cycles. Keeps private shadows of
//                the EX/MEM and MEM/WB destination fields so only ID and EX
//                taps are needed.
//  Ports       : clock, reset_n         - clock, async active-low reset
//                reg1_ID, reg2_ID       - rs/rt of the instruction in ID
//                reg1_EX, reg2_EX       - rs/rt of the instruction in EX
//                RD                     - destination picked by regDest mux
//                regWrite_EX            - EX instruction writes the reg file
//                memRead_EX             - EX instruction is a load
//                branchTaken_EX         - branch resolved taken in EX
//                saidaAfw, saidaBfw     - forward selects for operands A/B
//                stall_IF_ID            - hold PC and IF/ID
//                bubble_ID_EX           - zero ID/EX control on next edge
//                flush_IF_ID            - replace IF/ID with a NOP
//                stallCount             - saturating load-use stall count
//  Revision    : 1.0 - initial release
// ============================================================================
module forwarding_hazard_unit #(
   parameter int REG_W    = 3,
   parameter int CNT_W    = 16,
   parameter int ZERO_REG = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [REG_W-1:0] reg1_ID,
   input  logic [REG_W-1:0] reg2_ID,
   input  logic [REG_W-1:0] reg1_EX,
   input  logic [REG_W-1:0] reg2_EX,
   input  logic [REG_W-1:0] RD,
   input  logic             regWrite_EX,
   input  logic             memRead_EX,
   input  logic             branchTaken_EX,
   output logic [1:0]       saidaAfw,
   output logic [1:0]       saidaBfw,
   output logic             stall_IF_ID,
   output logic             bubble_ID_EX,
   output logic             flush_IF_ID,
   output logic [CNT_W-1:0] stallCount
);
   import forwarding_hazard_unit_pkg::*;

   localparam logic [CNT_W-1:0] c_cntMax = '1;
   localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [REG_W-1:0] r_exMemRd;
   logic             r_exMemWe;
   logic [REG_W-1:0] r_memWbRd;
   logic             r_memWbWe;
   logic             r_bubbleApplied;
   logic [CNT_W-1:0] r_stallCount;

   logic w_rdLive;
   logic w_loadUse;
   logic w_stall;
   logic w_bubble;
   logic w_flush;

   // ------------------------------------------------------------------------
   // Hazard and flush decisions. Outputs are qualified with reset_n so that
   // an asserted reset drops a pending stall at once, not at the next edge.
   // A taken branch squashes the instruction that would have been stalled,
   // so flush overrides the load-use stall.
   // ------------------------------------------------------------------------
   assign w_rdLive  = (ZERO_REG == 0) || (RD != '0);
   assign w_loadUse = memRead_EX && regWrite_EX && w_rdLive &&
                      ((RD == reg1_ID) || (RD == reg2_ID));

   assign w_flush  = reset_n && branchTaken_EX;
   assign w_stall  = reset_n && w_loadUse && !branchTaken_EX;
   assign w_bubble = reset_n && (w_loadUse || branchTaken_EX);

   assign stall_IF_ID  = w_stall;
   assign bubble_ID_EX = w_bubble;
   assign flush_IF_ID  = w_flush;
   assign stallCount   = r_stallCount;

   // ------------------------------------------------------------------------
   // Shadow pipeline. EX/MEM and MEM/WB never stall, so these advance every
   // edge. The instruction entering EX right after a bubble has its write
   // enable masked so a stale regWrite cannot produce a false forward.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_exMemRd       <= '0;
         r_exMemWe       <= 1'b0;
         r_memWbRd       <= '0;
         r_memWbWe       <= 1'b0;
         r_bubbleApplied <= 1'b0;
      end else begin
         r_exMemRd       <= RD;
         r_exMemWe       <= regWrite_EX && !r_bubbleApplied;
         r_memWbRd       <= r_exMemRd;
         r_memWbWe       <= r_exMemWe;
         r_bubbleApplied <= w_bubble;
      end
   end

   // Saturating load-use stall counter; holds at all-ones instead of wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stallCount <= '0;
      end else if (w_stall && (r_stallCount != c_cntMax)) begin
         r_stallCount <= r_stallCount + c_cntOne;
      end
   end

   // ------------------------------------------------------------------------
   // Operand forward selects.
   // ------------------------------------------------------------------------
   fwd_select #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
   ) u_fwdA (
      .srcReg  (reg1_EX),
      .exMemRd (r_exMemRd),
      .exMemWe (r_exMemWe),
      .memWbRd (r_memWbRd),
      .memWbWe (r_memWbWe),
      .fwdSel  (saidaAfw)
   );

   fwd_select #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
   ) u_fwdB (
      .srcReg  (reg2_EX),
      .exMemRd (r_exMemRd),
      .exMemWe (r_exMemWe),
      .memWbRd (r_memWbRd),
      .memWbWe (r_memWbWe),
      .fwdSel  (saidaBfw)
   );

endmodule
`default_nettype wire
